// File: rtl/ipv4_rx_dispatcher.sv
`timescale 1ns/1ps
// ipv4_rx_dispatcher
// Buffers one IPv4 payload from the header parser, then routes it to the UDP or
// TCP handler or throws it away, based on the metadata the parser presents
// at the end of the frame. A one-cycle meta_ready pulse releases the parser.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_*                 payload beats from the parser (tlast unused; meta_valid ends a frame)
//   meta_valid/meta_ready    frame metadata handshake (meta_ready is a release pulse)
//   meta_dst_ip/_protocol/_ethertype_ok   frame metadata
//   m_udp_axis_*             UDP payload output (protocol 17)
//   m_tcp_axis_*             TCP payload output (protocol 6)
//   m_icmp_axis_*            ICMP payload output (protocol 1), only with ICMP_PORT_EN
//   frame_dropped            one-cycle pulse per rejected frame
//   drop_count               saturating count of rejected frames
//
// Build option: define ICMP_PORT_EN to add the ICMP output port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | store incoming beats; wait for meta_valid
// DECIDE  | apply the filters; preload the first beat when accepted
// FORWARD | drain the buffer to the selected output port
// DISCARD | drain the buffer one beat per cycle with no output
// RELEASE | meta_ready pulse; clear pointers, count and overflow flag
module ipv4_rx_dispatcher #(
    parameter int          DATA_WIDTH = 8,
    parameter int          BUF_DEPTH  = 2048,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80164
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic                  meta_valid,
    output logic                  meta_ready,
    input  logic [31:0]           meta_dst_ip,
    input  logic [7:0]            meta_protocol,
    input  logic                  meta_ethertype_ok,
    output logic [DATA_WIDTH-1:0] m_udp_axis_tdata,
    output logic                  m_udp_axis_tvalid,
    input  logic                  m_udp_axis_tready,
    output logic                  m_udp_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_tcp_axis_tdata,
    output logic                  m_tcp_axis_tvalid,
    input  logic                  m_tcp_axis_tready,
    output logic                  m_tcp_axis_tlast,
`ifdef ICMP_PORT_EN
    output logic [DATA_WIDTH-1:0] m_icmp_axis_tdata,
    output logic                  m_icmp_axis_tvalid,
    input  logic                  m_icmp_axis_tready,
    output logic                  m_icmp_axis_tlast,
`endif
    output logic                  frame_dropped,
    output logic [15:0]           drop_count
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(BUF_DEPTH);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

    typedef enum logic [2:0] {COLLECT, DECIDE, FORWARD, DISCARD, RELEASE} state_t;
    typedef enum logic [1:0] {SEL_UDP, SEL_TCP, SEL_ICMP} sel_t;

    state_t                state;
    sel_t                  sel;
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           beat_cnt, rem_cnt;
    logic                  ovf;
    logic [31:0]           dst_ip_q;
    logic [7:0]            proto_q;
    logic                  eth_ok_q;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid, out_last;
    logic                  buf_full, wr_en, dst_ok, proto_ok, accept, sel_ready;

    // Frame boundaries come from meta_valid, so the parser's tlast is not needed.
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;

    assign s_axis_tready = (state == COLLECT);
    assign buf_full      = (beat_cnt == DEPTH_CNT);
    assign wr_en         = (state == COLLECT) && s_axis_tvalid && !buf_full;

    assign dst_ok = (dst_ip_q == LOCAL_IP) || (dst_ip_q == 32'hFFFF_FFFF);
`ifdef ICMP_PORT_EN
    assign proto_ok = (proto_q == 8'd17) || (proto_q == 8'd6) || (proto_q == 8'd1);
`else
    assign proto_ok = (proto_q == 8'd17) || (proto_q == 8'd6);
`endif
    assign accept = eth_ok_q && !ovf && (beat_cnt != '0) && dst_ok && proto_ok;

    always_comb begin
        sel_ready = 1'b0;
        case (sel)
            SEL_UDP:  sel_ready = m_udp_axis_tready;
            SEL_TCP:  sel_ready = m_tcp_axis_tready;
`ifdef ICMP_PORT_EN
            SEL_ICMP: sel_ready = m_icmp_axis_tready;
`endif
            default:  sel_ready = 1'b0;
        endcase
    end

    // One shared output register; each port only sees it while selected.
    assign m_udp_axis_tvalid = out_valid && (sel == SEL_UDP);
    assign m_udp_axis_tlast  = out_last  && (sel == SEL_UDP);
    assign m_udp_axis_tdata  = (sel == SEL_UDP) ? out_data : '0;
    assign m_tcp_axis_tvalid = out_valid && (sel == SEL_TCP);
    assign m_tcp_axis_tlast  = out_last  && (sel == SEL_TCP);
    assign m_tcp_axis_tdata  = (sel == SEL_TCP) ? out_data : '0;
`ifdef ICMP_PORT_EN
    assign m_icmp_axis_tvalid = out_valid && (sel == SEL_ICMP);
    assign m_icmp_axis_tlast  = out_last  && (sel == SEL_ICMP);
    assign m_icmp_axis_tdata  = (sel == SEL_ICMP) ? out_data : '0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= COLLECT;
            sel           <= SEL_UDP;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            beat_cnt      <= '0;
            rem_cnt       <= '0;
            ovf           <= 1'b0;
            dst_ip_q      <= '0;
            proto_q       <= '0;
            eth_ok_q      <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            meta_ready    <= 1'b0;
            frame_dropped <= 1'b0;
            drop_count    <= '0;
        end else begin
            meta_ready    <= 1'b0;
            frame_dropped <= 1'b0;
            case (state)
                COLLECT: begin
                    if (s_axis_tvalid) begin
                        if (buf_full) begin
                            ovf <= 1'b1;
                        end else begin
                            wr_ptr   <= wr_ptr + 1'b1;
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                    if (meta_valid) begin
                        dst_ip_q <= meta_dst_ip;
                        proto_q  <= meta_protocol;
                        eth_ok_q <= meta_ethertype_ok;
                        state    <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (accept) begin
                        if (proto_q == 8'd17)     sel <= SEL_UDP;
                        else if (proto_q == 8'd6) sel <= SEL_TCP;
                        else                      sel <= SEL_ICMP;
                        // Preload the first beat so tvalid rises on entry to FORWARD.
                        out_data  <= mem[rd_ptr];
                        out_valid <= 1'b1;
                        out_last  <= (beat_cnt == CNT_ONE);
                        rd_ptr    <= rd_ptr + 1'b1;
                        rem_cnt   <= beat_cnt - 1'b1;
                        state     <= FORWARD;
                    end else begin
                        frame_dropped <= 1'b1;
                        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                        if (beat_cnt == '0) begin
                            meta_ready <= 1'b1;
                            state      <= RELEASE;
                        end else begin
                            rem_cnt <= beat_cnt;
                            state   <= DISCARD;
                        end
                    end
                end
                FORWARD: begin
                    if (sel_ready) begin
                        if (out_last) begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            meta_ready <= 1'b1;
                            state      <= RELEASE;
                        end else begin
                            // rem_cnt counts beats not yet loaded into the output register.
                            out_data <= mem[rd_ptr];
                            out_last <= (rem_cnt == CNT_ONE);
                            rd_ptr   <= rd_ptr + 1'b1;
                            rem_cnt  <= rem_cnt - 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    rem_cnt <= rem_cnt - 1'b1;
                    if (rem_cnt == CNT_ONE) begin
                        meta_ready <= 1'b1;
                        state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    wr_ptr   <= '0;
                    rd_ptr   <= '0;
                    beat_cnt <= '0;
                    ovf      <= 1'b0;
                    state    <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_ipv4_rx_dispatcher.sv
`timescale 1ns/1ps
// Directed bench for ipv4_rx_dispatcher: frames are pushed through the parser-side
// interface and the routed output, drops and release pulses are compared against
// hand-computed expectations.
module tb_ipv4_rx_dispatcher;

    localparam logic [31:0] LOCAL_IP = 32'hC0A80164;
    localparam int          DEPTH    = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic        meta_valid = 1'b0;
    logic        meta_ready;
    logic [31:0] meta_dst_ip = '0;
    logic [7:0]  meta_protocol = '0;
    logic        meta_eth_ok = 1'b0;
    logic [7:0]  udp_tdata, tcp_tdata;
    logic        udp_tvalid, udp_tlast, tcp_tvalid, tcp_tlast;
    logic        udp_tready = 1'b0;
    logic        tcp_tready = 1'b0;
    logic        frame_dropped;
    logic [15:0] drop_count;
`ifdef ICMP_PORT_EN
    logic [7:0]  icmp_tdata;
    logic        icmp_tvalid, icmp_tlast;
    logic        icmp_tready = 1'b1;
    logic [8:0]  icmp_q[$];
`endif

    int total = 0;
    int bad   = 0;
    int exp_drops = 0;

    // Written only by the monitor below.
    logic [8:0] udp_q[$];
    logic [8:0] tcp_q[$];
    int mr_cnt = 0, fd_cnt = 0, udp_vcyc = 0, tcp_vcyc = 0;

    ipv4_rx_dispatcher #(.DATA_WIDTH(8), .BUF_DEPTH(DEPTH), .LOCAL_IP(LOCAL_IP)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis_tdata      (s_tdata),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tlast      (s_tlast),
        .s_axis_tready     (s_tready),
        .meta_valid        (meta_valid),
        .meta_ready        (meta_ready),
        .meta_dst_ip       (meta_dst_ip),
        .meta_protocol     (meta_protocol),
        .meta_ethertype_ok (meta_eth_ok),
        .m_udp_axis_tdata  (udp_tdata),
        .m_udp_axis_tvalid (udp_tvalid),
        .m_udp_axis_tready (udp_tready),
        .m_udp_axis_tlast  (udp_tlast),
        .m_tcp_axis_tdata  (tcp_tdata),
        .m_tcp_axis_tvalid (tcp_tvalid),
        .m_tcp_axis_tready (tcp_tready),
        .m_tcp_axis_tlast  (tcp_tlast),
`ifdef ICMP_PORT_EN
        .m_icmp_axis_tdata (icmp_tdata),
        .m_icmp_axis_tvalid(icmp_tvalid),
        .m_icmp_axis_tready(icmp_tready),
        .m_icmp_axis_tlast (icmp_tlast),
`endif
        .frame_dropped     (frame_dropped),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (udp_tvalid) udp_vcyc++;
            if (tcp_tvalid) tcp_vcyc++;
            if (udp_tvalid && udp_tready) udp_q.push_back({udp_tlast, udp_tdata});
            if (tcp_tvalid && tcp_tready) tcp_q.push_back({tcp_tlast, tcp_tdata});
`ifdef ICMP_PORT_EN
            if (icmp_tvalid && icmp_tready) icmp_q.push_back({icmp_tlast, icmp_tdata});
`endif
            if (meta_ready) mr_cnt++;
            if (frame_dropped) fd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(first + i);
            tick();
        end
        s_tvalid = 1'b0;
    endtask

    // Leaves the caller in the DECIDE cycle.
    task automatic send_meta(input logic [31:0] dst, input logic [7:0] proto, input logic eth_ok);
        meta_valid    = 1'b1;
        meta_dst_ip   = dst;
        meta_protocol = proto;
        meta_eth_ok   = eth_ok;
        tick();
        meta_valid    = 1'b0;
    endtask

    task automatic wait_release(input string tag, input int budget);
        int c;
        c = 0;
        while (!meta_ready && c < budget) begin
            tick();
            c++;
        end
        chk({tag, "_release"}, 32'(meta_ready), 32'd1);
        tick();
    endtask

    task automatic check_q(input string tag, input logic [8:0] q[$], input int base,
                           input int n, input logic [7:0] first);
        chk({tag, "_len"}, 32'(q.size() - base), 32'(n));
        for (int i = 0; i < n && base + i < q.size(); i++)
            chk({tag, "_beat"}, 32'(q[base + i]), 32'({(i == n - 1), 8'(first + i)}));
    endtask

    initial begin
        int base, mr0, fd0, uv0, tv0;
        logic        hold;
        logic [9:0]  prev;
        logic [7:0]  got_d [4];
        logic        got_l [4];
        int          ng;

        // ---- reset values
        tick(); tick();
        chk("rst_s_tready", 32'(s_tready), 32'd1);
        chk("rst_meta_ready", 32'(meta_ready), 32'd0);
        chk("rst_dropped", 32'(frame_dropped), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        chk("rst_outs", 32'({udp_tvalid, udp_tlast, udp_tdata, tcp_tvalid, tcp_tlast, tcp_tdata}), 32'd0);
        rst = 1'b0;
        tick();

        // ---- UDP frame, 8 beats, exact cycle timing
        send_frame(8, 8'h01);
        udp_tready = 1'b1;
        mr0 = mr_cnt;
        send_meta(LOCAL_IP, 8'd17, 1'b1);
        chk("udp_decide_tvalid", 32'(udp_tvalid), 32'd0);
        chk("udp_decide_s_tready", 32'(s_tready), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("udp_tvalid", 32'(udp_tvalid), 32'd1);
            chk("udp_tdata", 32'(udp_tdata), 32'(i + 1));
            chk("udp_tlast", 32'(udp_tlast), 32'(i == 7));
            tick();
        end
        chk("udp_meta_ready", 32'(meta_ready), 32'd1);
        tick();
        chk("udp_meta_ready_off", 32'(meta_ready), 32'd0);
        chk("udp_release_once", 32'(mr_cnt - mr0), 32'd1);
        chk("udp_drop_count", 32'(drop_count), 32'd0);
        chk("udp_idle_tvalid", 32'(udp_tvalid), 32'd0);

        // ---- TCP frame, tready toggling, stall stability
        send_frame(4, 8'hA1);
        uv0 = udp_vcyc;
        send_meta(LOCAL_IP, 8'd6, 1'b1);
        hold = 1'b0;
        prev = '0;
        ng = 0;
        for (int c = 0; c < 40; c++) begin
            tcp_tready = (c % 2 == 0);
            #0;
            if (hold) chk("tcp_stable", 32'({tcp_tvalid, tcp_tlast, tcp_tdata}), 32'(prev));
            chk("tcp_udp_quiet", 32'(udp_tvalid), 32'd0);
            if (tcp_tvalid && tcp_tready && ng < 4) begin
                got_d[ng] = tcp_tdata;
                got_l[ng] = tcp_tlast;
                ng++;
            end
            hold = tcp_tvalid && !tcp_tready;
            prev = {tcp_tvalid, tcp_tlast, tcp_tdata};
            if (meta_ready) break;
            tick();
        end
        chk("tcp_release", 32'(meta_ready), 32'd1);
        chk("tcp_count", 32'(ng), 32'd4);
        for (int i = 0; i < ng; i++) begin
            chk("tcp_data", 32'(got_d[i]), 32'(8'hA1 + i));
            chk("tcp_last", 32'(got_l[i]), 32'(i == 3));
        end
        tick();
        tcp_tready = 1'b0;
        chk("tcp_udp_vcyc", 32'(udp_vcyc - uv0), 32'd0);

        // ---- filtered frames: foreign dst, bad ethertype
        fd0 = fd_cnt; mr0 = mr_cnt; uv0 = udp_vcyc; tv0 = tcp_vcyc;
        send_frame(3, 8'h61);
        send_meta(32'h0A000009, 8'd17, 1'b1);
        wait_release("flt_dst", 20);
        send_frame(2, 8'h71);
        send_meta(LOCAL_IP, 8'd17, 1'b0);
        wait_release("flt_eth", 20);
        exp_drops = 2;
        chk("flt_dropped_pulses", 32'(fd_cnt - fd0), 32'd2);
        chk("flt_drop_count", 32'(drop_count), 32'(exp_drops));
        chk("flt_meta_ready", 32'(mr_cnt - mr0), 32'd2);
        chk("flt_no_output", 32'((udp_vcyc - uv0) + (tcp_vcyc - tv0)), 32'd0);

        // ---- empty frame goes straight to release and is counted
        send_meta(LOCAL_IP, 8'd17, 1'b1);
        wait_release("empty", 4);
        exp_drops++;
        chk("empty_drop_count", 32'(drop_count), 32'(exp_drops));

        // ---- protocol 1
        base = udp_q.size() + tcp_q.size();
        send_frame(2, 8'h81);
        send_meta(LOCAL_IP, 8'd1, 1'b1);
        wait_release("icmp", 20);
`ifdef ICMP_PORT_EN
        check_q("icmp", icmp_q, 0, 2, 8'h81);
`else
        exp_drops++;
`endif
        chk("icmp_drop_count", 32'(drop_count), 32'(exp_drops));
        chk("icmp_not_routed", 32'(udp_q.size() + tcp_q.size()), 32'(base));

        // ---- overflow, then a good frame
        send_frame(DEPTH + 5, 8'h00);
        send_meta(LOCAL_IP, 8'd17, 1'b1);
        wait_release("ovf", DEPTH + 20);
        exp_drops++;
        chk("ovf_drop_count", 32'(drop_count), 32'(exp_drops));
        base = udp_q.size();
        send_frame(3, 8'h31);
        send_meta(LOCAL_IP, 8'd17, 1'b1);
        wait_release("post_ovf", 20);
        check_q("post_ovf", udp_q, base, 3, 8'h31);

        // ---- reset mid-forward
        base = udp_q.size();
        send_frame(6, 8'h41);
        send_meta(LOCAL_IP, 8'd17, 1'b1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_udp", 32'({udp_tvalid, udp_tlast, udp_tdata}), 32'd0);
        chk("mid_rst_meta_ready", 32'(meta_ready), 32'd0);
        chk("mid_rst_drop_count", 32'(drop_count), 32'd0);
        chk("mid_rst_s_tready", 32'(s_tready), 32'd1);
        chk("mid_rst_partial", 32'(udp_q.size() - base), 32'd2);
        if (udp_q.size() >= base + 2) chk("mid_rst_beat2", 32'(udp_q[base + 1]), 32'h042);
        rst = 1'b0;
        exp_drops = 0;
        tick();
        base = udp_q.size();
        send_frame(4, 8'h51);
        send_meta(LOCAL_IP, 8'd17, 1'b1);
        wait_release("post_rst", 20);
        check_q("post_rst", udp_q, base, 4, 8'h51);
        chk("post_rst_drop_count", 32'(drop_count), 32'd0);

        // ---- broadcast to TCP
        base = tcp_q.size();
        tcp_tready = 1'b1;
        send_frame(2, 8'hB1);
        send_meta(32'hFFFFFFFF, 8'd6, 1'b1);
        wait_release("bcast", 20);
        check_q("bcast", tcp_q, base, 2, 8'hB1);

        // ---- saturation: start just below the ceiling
        force dut.drop_count = 16'hFFFE;
        #1;
        release dut.drop_count;
        fd0 = fd_cnt;
        send_meta(LOCAL_IP, 8'd17, 1'b1);
        wait_release("sat1", 4);
        chk("sat_reach", 32'(drop_count), 32'hFFFF);
        send_meta(LOCAL_IP, 8'd17, 1'b1);
        wait_release("sat2", 4);
        chk("sat_hold", 32'(drop_count), 32'hFFFF);
        chk("sat_pulses", 32'(fd_cnt - fd0), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
